bcd_multidigit_counter: RTL and testbench
=========================================

# bcd_multidigit_counter

Parametrised multi-decade BCD counter, the successor to the team's single-digit 0–9 counter. It chains DIGITS decade cells into one synchronous up/down counter with count enable, parallel load, terminal-count flag and a registered wrap pulse. It drives multi-digit seven-segment display paths and event tallies, and can feed the next counter stage through its wrap pulse.

## Interface
Parameters:
- DIGITS, 4, number of BCD decades; legal range 1–8.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  count enable; one step per cycle while high.
- up  in  1  direction: 1 counts up, 0 counts down.
- load  in  1  synchronous parallel load.
- load_val  in  4*DIGITS  BCD load value; digit 0 is in bits [3:0].
- count  out  4*DIGITS  current BCD value; digit 0 is the least significant.
- tc  out  1  terminal count. It is combinational from count and up: high at all-9s when up=1, high at all-0s when up=0.
- co  out  1  registered wrap pulse. It is high for one cycle after a step that wrapped or saturated at the boundary.
- load_err  out  1  registered. It is high for one cycle after a load that contained a non-BCD digit.

## Operation
- Reset (rst=0, asynchronous): count=0, co=0, load_err=0. The outputs hold these values until the first rising edge after rst is released.
- Priority per edge: load > en > hold.
- Load:
  - count takes load_val.
  - Any digit greater than 9 is loaded as 0, and load_err=1 on the next cycle.
  - co=0 on a load cycle, and en is ignored.
- Up step: digit k increments when every lower digit is 9. A digit at 9 that steps goes to 0.
- Down step: digit k decrements when every lower digit is 0. A digit at 0 that steps goes to 9.
- Wrap: up from all-9s gives all-0s, and down from all-0s gives all-9s. In both cases co=1 the following cycle.
- Hold (en=0, load=0): count is unchanged; co=0 and load_err=0.
- Direction change: up is sampled on every edge, so reversal takes effect on the next step. No dead cycle.
- Reset during counting or loading: reset wins immediately and all state clears.
- count never holds a non-BCD digit under any input sequence.

## Timing
- Step latency: one clock from an en=1 edge to the updated count.
- Load latency: one clock.
- tc is combinational, with zero latency from count and up. co and load_err are registered, valid one cycle after the causing edge.
- The carry chain is combinational across DIGITS. For DIGITS=8 the timing path is the 8-deep lookahead; no pipelining.
- Chaining: connect co to the next stage's en. The next stage steps one cycle after the wrap.

## Configuration
- BCD_COUNTER_SATURATE_EN:
  - When defined, the counter saturates instead of wrapping. Up at all-9s holds all-9s; down at all-0s holds all-0s.
  - co still pulses on each blocked step, so an overflow attempt stays visible.
- Undefined (default): wrap-around behaviour as above.

## Structure
- Shared package bcd_pkg holds:
  - the BCD digit typedef (4-bit);
  - the constants BCD_MAX=9 and BCD_MIN=0;
  - the digit-validity helper function.
- Sub-module bcd_digit_cell: one decade.
  - Inputs: step, up, load, load digit.
  - Outputs: digit, digit-at-terminal flag (used for the carry/borrow chain), invalid-load flag.
  - The top instantiates DIGITS cells with a generate loop and ANDs the terminal flags to form the chain.

## Test plan
Run with DIGITS=2 unless stated.
- Reset: rst low mid-count at 47 -> count=00 immediately; co=0; load_err=0.
- Up with wrap: load 98, en=1, up=1 for 3 cycles -> 99, 00, 01; tc high while at 99; co high exactly the cycle count shows 00.
- Down with borrow: load 10, en=1, up=0 -> 09, 08; then load 00 and step -> 99; co pulses.
- Load priority and invalid digits: load=1 and en=1 together with load_val=0xA5 -> count=05, load_err=1 for one cycle, co=0.
- Direction reversal: at 09 step up then down on consecutive cycles -> 10 then 09. With DIGITS=4, load 0999 and step up -> 1000.
- Saturation build (BCD_COUNTER_SATURATE_EN): at 99 step up twice -> count stays 99, co pulses on each blocked step; at 00 step down -> count stays 00.

Source files
------------

// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Types and constants shared by the BCD counter slice. Contents:
//   bcd_t     - one BCD decade (4 bits)
//   BCD_MAX   - largest legal decade value (9)
//   BCD_MIN   - smallest legal decade value (0)
//   bcd_valid - returns 1 when a 4-bit value is a legal BCD digit
// ---------------------------------------------------------------------------
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    function automatic logic bcd_valid(input bcd_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// ---------------------------------------------------------------------------
// bcd_digit_cell
// One decade of the multi-digit BCD counter. It holds a single BCD digit.
// The digit steps up or down when 'step' is high, and a parallel load
// takes priority over stepping. An illegal load digit is stored as 0.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset (digit -> 0)
//   step     in   advance this decade by one this cycle
//   up       in   direction: 1 = increment, 0 = decrement
//   load     in   parallel load of load_dig
//   load_dig in   digit to load (values above 9 are replaced by 0)
//   digit    out  current digit value
//   term     out  digit is at its terminal value for the current direction
//                 (9 when counting up, 0 when counting down)
//   load_bad out  combinational: this cycle's load carries a non-BCD digit
// ---------------------------------------------------------------------------
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic up,
    input  logic load,
    input  bcd_t load_dig,
    output bcd_t digit,
    output logic term,
    output logic load_bad
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit <= BCD_MIN;
        end else if (load) begin
            digit <= bcd_valid(load_dig) ? load_dig : BCD_MIN;
        end else if (step) begin
            if (up)
                digit <= (digit == BCD_MAX) ? BCD_MIN : bcd_t'(digit + 4'd1);
            else
                digit <= (digit == BCD_MIN) ? BCD_MAX : bcd_t'(digit - 4'd1);
        end
    end

    always_comb begin
        term     = up ? (digit == BCD_MAX) : (digit == BCD_MIN);
        load_bad = load & ~bcd_valid(load_dig);
    end

endmodule

// File: rtl/bcd_multidigit_counter.sv
// ---------------------------------------------------------------------------
// bcd_multidigit_counter
// Synchronous up/down BCD counter built from DIGITS decade cells (legal
// range 1..8). It has count enable, parallel load (priority
// load > en > hold), a combinational terminal-count flag, a registered
// wrap pulse and a registered invalid-load flag.
//
// Build option:
//   BCD_COUNTER_SATURATE_EN - when defined, the counter saturates at
//   all-9s (up) or all-0s (down) instead of wrapping. co still pulses on
//   every blocked step.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   en       in   count enable, one step per cycle
//   up       in   direction: 1 = up, 0 = down
//   load     in   synchronous parallel load
//   load_val in   BCD load value, digit 0 in bits [3:0]
//   count    out  current BCD value, digit 0 least significant
//   tc       out  terminal count (all-9s when up, all-0s when down)
//   co       out  one-cycle pulse after a step that wrapped or saturated
//   load_err out  one-cycle pulse after a load with a non-BCD digit
// ---------------------------------------------------------------------------
module bcd_multidigit_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                co,
    output logic                load_err
);

    logic [DIGITS-1:0] term;
    logic [DIGITS-1:0] bad;
    logic [DIGITS-1:0] step;
    // chain[k] is high when every decade below k is at its terminal value.
    logic [DIGITS:0]   chain;
    logic              advance;
    logic              blocked;

    assign chain[0] = 1'b1;
    assign advance  = en & ~load;
    assign tc       = chain[DIGITS];

`ifdef BCD_COUNTER_SATURATE_EN
    // At the boundary, the step is suppressed so the value sticks.
    assign blocked = tc;
`else
    assign blocked = 1'b0;
`endif

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign chain[k+1] = chain[k] & term[k];
        assign step[k]    = advance & chain[k] & ~blocked;

        bcd_digit_cell u_cell (
            .clk      (clk),
            .rst      (rst),
            .step     (step[k]),
            .up       (up),
            .load     (load),
            .load_dig (load_val[4*k +: 4]),
            .digit    (count[4*k +: 4]),
            .term     (term[k]),
            .load_bad (bad[k])
        );
    end

    // A step taken while at terminal count is either a wrap or a blocked
    // saturating step; both report through co on the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            co       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            co       <= advance & tc;
            load_err <= |bad;
        end
    end

endmodule

// File: tb/tb_bcd_multidigit_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_multidigit_counter
// Drives the counter with directed and random stimulus. An integer
// reference model predicts each cycle's result and pushes it into a queue.
// A monitor pops one entry after every rising edge and compares it with
// the DUT outputs.
// ---------------------------------------------------------------------------
module tb_bcd_multidigit_counter;

    localparam int D    = 4;
    localparam int W    = 4 * D;
    localparam int MAXV = 9999;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count;
    logic         tc;
    logic         co;
    logic         load_err;

    typedef struct {
        int val;
        bit co;
        bit err;
    } exp_t;

    exp_t q[$];
    int   model_val = 0;
    int   tests = 0;
    int   fails = 0;

    bcd_multidigit_counter #(.DIGITS(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .co       (co),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    function automatic int bcd2int(input logic [W-1:0] b);
        int v = 0;
        for (int i = D - 1; i >= 0; i--) begin
            int d = int'(b[4*i +: 4]);
            v = v * 10 + ((d > 9) ? 0 : d);
        end
        return v;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [W-1:0] b);
        for (int i = 0; i < D; i++)
            if (b[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus. Inputs change on the falling edge. The model
    // result for the following rising edge is queued.
    task automatic cyc(input bit r, input bit e, input bit u, input bit l,
                       input logic [W-1:0] lv);
        exp_t x;
        bit   was_running;
        @(negedge clk);
        was_running = rst;
        rst = r; en = e; up = u; load = l; load_val = lv;
        if (!r) begin
            model_val = 0;
            x = '{0, 1'b0, 1'b0};
        end else if (l) begin
            model_val = bcd2int(lv);
            x = '{model_val, 1'b0, has_bad(lv)};
        end else if (e) begin
            bit wrap;
            wrap = u ? (model_val == MAXV) : (model_val == 0);
`ifdef BCD_COUNTER_SATURATE_EN
            if (!wrap) model_val = u ? model_val + 1 : model_val - 1;
`else
            model_val = u ? (model_val + 1) % (MAXV + 1)
                          : (model_val + MAXV) % (MAXV + 1);
`endif
            x = '{model_val, wrap, 1'b0};
        end else begin
            x = '{model_val, 1'b0, 1'b0};
        end
        q.push_back(x);
        if (was_running && !r) begin
            #1;
            chk("async_reset_count", 32'(count), 32'(0));
            chk("async_reset_co", 32'(co), 32'(0));
            chk("async_reset_err", 32'(load_err), 32'(0));
        end
    endtask

    // Monitor: every edge yields one result.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("count", 32'(count), 32'(int2bcd(x.val)));
            chk("co", 32'(co), 32'(x.co));
            chk("load_err", 32'(load_err), 32'(x.err));
            chk("tc", 32'(tc), 32'(up ? (x.val == MAXV) : (x.val == 0)));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // held in reset, then released
        cyc(0, 0, 1, 0, '0);
        cyc(0, 1, 1, 0, '0);
        cyc(1, 0, 1, 0, '0);
        // reset mid-count at 47
        cyc(1, 0, 1, 1, 16'h0045);
        cyc(1, 1, 1, 0, '0);
        cyc(1, 1, 1, 0, '0);
        cyc(0, 1, 1, 0, '0);
        cyc(1, 1, 1, 0, '0);
        // up with wrap
        cyc(1, 0, 1, 1, 16'h9998);
        cyc(1, 1, 1, 0, '0);
        cyc(1, 1, 1, 0, '0);
        cyc(1, 1, 1, 0, '0);
        cyc(1, 0, 1, 0, '0);
        // down with borrow, then wrap below zero
        cyc(1, 0, 0, 1, 16'h0010);
        cyc(1, 1, 0, 0, '0);
        cyc(1, 1, 0, 0, '0);
        cyc(1, 0, 0, 1, 16'h0000);
        cyc(1, 1, 0, 0, '0);
        cyc(1, 1, 0, 0, '0);
        // load beats enable; invalid digits load as 0
        cyc(1, 1, 1, 1, 16'h00A5);
        cyc(1, 0, 1, 0, '0);
        cyc(1, 1, 0, 1, 16'hF9B3);
        cyc(1, 0, 0, 0, '0);
        // direction reversal, and a carry across three decades
        cyc(1, 0, 1, 1, 16'h0009);
        cyc(1, 1, 1, 0, '0);
        cyc(1, 1, 0, 0, '0);
        cyc(1, 0, 1, 1, 16'h0999);
        cyc(1, 1, 1, 0, '0);
        cyc(1, 1, 0, 0, '0);
        // boundary stepping (wrap or saturate depending on build)
        cyc(1, 0, 1, 1, 16'h9999);
        cyc(1, 1, 1, 0, '0);
        cyc(1, 1, 1, 0, '0);
        cyc(1, 0, 0, 1, 16'h0000);
        cyc(1, 1, 0, 0, '0);
        cyc(1, 1, 0, 0, '0);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [W-1:0] lv;
            int sel;
            sel = int'($urandom_range(0, 5));
            case (sel)
                0:       lv = 16'h9999;
                1:       lv = 16'h0000;
                2:       lv = 16'h9998;
                3:       lv = 16'h0001;
                default: lv = W'($urandom);
            endcase
            cyc($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, lv);
        end
        cyc(1, 0, 1, 0, '0);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
